// File: rtl/instr_buffer.sv
// Circular instruction queue between fetch and decode: up to two pushes and
// two pops per cycle, head entries presented in program order.
module instr_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [1:0]                 fetch_valid,
    input  logic [63:0]                fetch_pc,
    input  logic [63:0]                fetch_inst,
    input  logic [1:0]                 fetch_excp,
    output logic                       fetch_ready,
    output logic [1:0]                 dec_valid,
    output logic [63:0]                dec_pc,
    output logic [63:0]                dec_inst,
    output logic [1:0]                 dec_excp,
    input  logic [1:0]                 dec_pop,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a fetch slot transfers when its fetch_valid bit is set and
    // fetch_ready is high; a decode slot transfers when dec_pop and dec_valid
    // are both set, with slot 1 only transferring alongside slot 0.

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic        excp_mem [DEPTH];

    logic [AW-1:0] head, tail;
    logic [AW-1:0] head_p1, tail_p1;
    logic [1:0]    push_n, pop_n;
    logic [CW-1:0] count_next;
    logic [31:0]   first_pc, first_inst;
    logic          first_excp;
    logic          pop0;

    assign head_p1 = head + AW'(1);
    assign tail_p1 = tail + AW'(1);

    // Ready comes from the registered count only, so decode stalls never
    // reach back into fetch combinationally.
    assign fetch_ready = (count <= CW'(DEPTH - 2));

    assign dec_valid[0] = (count != '0);
    assign dec_valid[1] = (count >= CW'(2));

    always_comb begin
        push_n = 2'd0;
        if (fetch_ready) begin
            push_n = {1'b0, fetch_valid[0]} + {1'b0, fetch_valid[1]};
        end
    end

    assign pop0  = dec_pop[0] & dec_valid[0];
    assign pop_n = {1'b0, pop0} + {1'b0, pop0 & dec_pop[1] & dec_valid[1]};

    assign count_next = count + CW'(push_n) - CW'(pop_n);

    // Compaction: the oldest valid fetch slot always lands at tail.
    always_comb begin
        first_pc   = fetch_pc[31:0];
        first_inst = fetch_inst[31:0];
        first_excp = fetch_excp[0];
        if (!fetch_valid[0]) begin
            first_pc   = fetch_pc[63:32];
            first_inst = fetch_inst[63:32];
            first_excp = fetch_excp[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count_next;
        end
    end

    // Storage is never cleared; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push_n != 2'd0) begin
                pc_mem[tail]   <= first_pc;
                inst_mem[tail] <= first_inst;
                excp_mem[tail] <= first_excp;
            end
            if (push_n == 2'd2) begin
                pc_mem[tail_p1]   <= fetch_pc[63:32];
                inst_mem[tail_p1] <= fetch_inst[63:32];
                excp_mem[tail_p1] <= fetch_excp[1];
            end
        end
    end

    always_comb begin
        dec_pc   = '0;
        dec_inst = '0;
        dec_excp = '0;
        if (dec_valid[0]) begin
            dec_pc[31:0]   = pc_mem[head];
            dec_inst[31:0] = inst_mem[head];
            dec_excp[0]    = excp_mem[head];
        end
        if (dec_valid[1]) begin
            dec_pc[63:32]   = pc_mem[head_p1];
            dec_inst[63:32] = inst_mem[head_p1];
            dec_excp[1]     = excp_mem[head_p1];
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer: reset, fill/full, steady streaming across
// wrap, flush, single-slot push with exception, and mid-stream reset.
module tb_instr_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  fetch_valid;
    logic [63:0] fetch_pc;
    logic [63:0] fetch_inst;
    logic [1:0]  fetch_excp;
    logic        fetch_ready;
    logic [1:0]  dec_valid;
    logic [63:0] dec_pc;
    logic [63:0] dec_inst;
    logic [1:0]  dec_excp;
    logic [1:0]  dec_pop;
    logic [3:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    instr_buffer #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_inst(fetch_inst), .fetch_excp(fetch_excp),
        .fetch_ready(fetch_ready), .dec_valid(dec_valid),
        .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_excp(dec_excp),
        .dec_pop(dec_pop), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        flush = 0; fetch_valid = 2'b00; dec_pop = 2'b00; fetch_excp = 2'b00;
    endtask

    task automatic push2(input logic [31:0] pc0);
        fetch_valid = 2'b11;
        fetch_pc    = {pc0 + 32'd4, pc0};
        fetch_inst  = {pc0 + 32'h104, pc0 + 32'h100};
        fetch_excp  = 2'b00;
    endtask

    initial begin
        logic [31:0] next_pc, head_pc;
        rst = 1; fetch_pc = '0; fetch_inst = '0;
        idle();
        step(); step();
        rst = 0;

        check("rst_ready", fetch_ready, 1);
        check("rst_valid", dec_valid, 0);
        check("rst_pc", dec_pc, 0);
        check("rst_inst", dec_inst, 0);
        check("rst_excp", dec_excp, 0);
        check("rst_count", count, 0);

        // two real instructions
        fetch_valid = 2'b11;
        fetch_pc    = {32'h1C000004, 32'h1C000000};
        fetch_inst  = {32'h1C000022, 32'h14000021};
        step(); idle();
        check("t1_valid", dec_valid, 2'b11);
        check("t1_pc", dec_pc, {32'h1C000004, 32'h1C000000});
        check("t1_inst", dec_inst, {32'h1C000022, 32'h14000021});
        check("t1_count", count, 2);

        // fill to 8
        push2(32'h1C000008); step();
        push2(32'h1C000010); step();
        push2(32'h1C000018); step(); idle();
        check("full_count", count, 8);
        check("full_ready", fetch_ready, 0);
        push2(32'h1C000020); step(); idle();
        check("full_push_count", count, 8);
        check("full_head_pc", dec_pc, {32'h1C000004, 32'h1C000000});
        // full: push still blocked while popping
        push2(32'h1C000020); dec_pop = 2'b11; step(); idle();
        check("pop_count", count, 6);
        check("pop_ready", fetch_ready, 1);
        check("pop_pc", dec_pc, {32'h1C00000C, 32'h1C000008});
        dec_pop = 2'b11; step(); idle();
        check("pop2_count", count, 4);
        check("pop2_pc", dec_pc, {32'h1C000014, 32'h1C000010});

        // steady 2-in/2-out across pointer wrap
        next_pc = 32'h1C000020;
        head_pc = 32'h1C000010;
        for (int i = 0; i < 12; i++) begin
            push2(next_pc); dec_pop = 2'b11;
            step(); idle();
            next_pc += 32'd8;
            head_pc += 32'd8;
            check("steady_count", count, 4);
            check("steady_pc", dec_pc, {head_pc + 32'd4, head_pc});
            check("steady_inst", dec_inst, {head_pc + 32'h104, head_pc + 32'h100});
        end

        // flush overrides simultaneous push and pop
        dec_pop = 2'b01; step(); idle();
        check("pre_flush_count", count, 3);
        flush = 1; push2(32'h1C000100); dec_pop = 2'b11; step(); idle();
        check("flush_count", count, 0);
        check("flush_valid", dec_valid, 0);
        check("flush_pc", dec_pc, 0);
        check("flush_ready", fetch_ready, 1);

        // only slot 1 valid, with fetch exception
        fetch_valid = 2'b10;
        fetch_pc    = {32'h1C000010, 32'hDEADBEEF};
        fetch_inst  = {32'h02800000, 32'hFFFFFFFF};
        fetch_excp  = 2'b10;
        step(); idle();
        check("s1_valid", dec_valid, 2'b01);
        check("s1_pc", dec_pc, {32'h0, 32'h1C000010});
        check("s1_inst", dec_inst, {32'h0, 32'h02800000});
        check("s1_excp", dec_excp, 2'b01);
        dec_pop = 2'b10; step(); idle();
        check("pop_hi_only", count, 1);
        dec_pop = 2'b11; step(); idle();
        check("pop_over", count, 0);
        check("pop_over_valid", dec_valid, 0);

        // push and pop while empty: pop ignored
        fetch_valid = 2'b01;
        fetch_pc    = {32'h0, 32'h1C000030};
        fetch_inst  = {32'h0, 32'h00100C21};
        dec_pop     = 2'b11;
        step(); idle();
        check("empty_pp_count", count, 1);
        check("empty_pp_pc", dec_pc, {32'h0, 32'h1C000030});

        // mid-stream reset
        push2(32'h1C000200); step();
        push2(32'h1C000208); step(); idle();
        check("pre_rst_count", count, 5);
        rst = 1; push2(32'h1C000300); dec_pop = 2'b11; step(); idle(); rst = 0;
        check("mrst_ready", fetch_ready, 1);
        check("mrst_valid", dec_valid, 0);
        check("mrst_pc", dec_pc, 0);
        check("mrst_inst", dec_inst, 0);
        check("mrst_excp", dec_excp, 0);
        check("mrst_count", count, 0);
        push2(32'h1C000040); step(); idle();
        check("post_rst_valid", dec_valid, 2'b11);
        check("post_rst_pc", dec_pc, {32'h1C000044, 32'h1C000040});
        check("post_rst_count", count, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
